// File: rtl/cv_mem_mapper.sv
// rtl/cv_mem_mapper.sv - windowed Z80 memory/bank mapper with I/O config and hotspot paging
module cv_mem_mapper #(
   parameter int                          WIN_BITS  = 2,
   parameter int                          SRC_W     = 2,
   parameter int                          PAGE_W    = 6,
   parameter logic [7:0]                  CFG_BASE  = 8'h70,
   parameter int                          HOT_WIN   = 3,
   parameter bit                          HOT_EN    = 1'b1,
   parameter logic [8*(2**WIN_BITS)-1:0]  RESET_MAP = '0
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [15:0]             a_i,
   input  logic [7:0]              d_i,
   input  logic                    iorq_n_i,
   input  logic                    mreq_n_i,
   input  logic                    rd_n_i,
   input  logic                    wr_n_i,
   input  logic                    rfsh_n_i,
   input  logic [PAGE_W-1:0]       page_mask_i,
   output logic [2**SRC_W-1:0]     src_ce_n_o,
   output logic [PAGE_W-1:0]       page_o,
   output logic [WIN_BITS-1:0]     win_o,
   output logic [7:0]              cfg_rd_data_o,
   output logic                    cfg_rd_en_o
);

   localparam int                  NWIN    = 2**WIN_BITS;
   localparam int                  PG_LO   = SRC_W;
   localparam int                  PG_HI   = SRC_W + PAGE_W - 1;
   localparam logic [WIN_BITS-1:0] HOT_IDX = HOT_WIN[WIN_BITS-1:0];

   logic [7:0]          cfg [NWIN];
   logic [WIN_BITS-1:0] win;
   logic [WIN_BITS-1:0] cfg_idx;
   logic [SRC_W-1:0]    cur_src;
   logic                port_hit;
   logic                iows;
   logic                iows_d;
   logic                iors;
   logic                iow_edge;
   logic                hs_edge;
   logic [PAGE_W-1:0]   hs_page;

   assign win      = a_i[15:16-WIN_BITS];
   assign cfg_idx  = a_i[WIN_BITS-1:0];
   assign cur_src  = cfg[win][SRC_W-1:0];
   assign win_o    = win;
   assign page_o   = cfg[win][PG_HI:PG_LO];

   assign port_hit = (a_i[7:WIN_BITS] == CFG_BASE[7:WIN_BITS]);
   assign iows     = ~iorq_n_i & mreq_n_i & rfsh_n_i & ~wr_n_i & port_hit;
   assign iors     = ~iorq_n_i & ~rd_n_i & port_hit;
   assign iow_edge = iows & ~iows_d;

   // Hotspot page offset: bank bits come from a_i[5:0]; wider page fields are zero-extended.
   for (genvar b = 0; b < PAGE_W; b++) begin : g_hs_page
      if (b < 6) begin : g_addr_bit
         assign hs_page[b] = a_i[b] & page_mask_i[b];
      end else begin : g_zero_bit
         assign hs_page[b] = 1'b0;
      end
   end

   if (HOT_EN) begin : g_hot
      logic hs;
      logic hs_d;

      assign hs      = ~mreq_n_i & rfsh_n_i & ~rd_n_i & (&a_i[15:6]);
      assign hs_edge = hs & ~hs_d;

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            hs_d <= 1'b0;
         end else begin
            hs_d <= hs;
         end
      end
   end else begin : g_no_hot
      assign hs_edge = 1'b0;
   end

   // A held I/O write updates once; it also overrides any coincident hotspot edge.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         iows_d <= 1'b0;
         for (int i = 0; i < NWIN; i++) begin
            cfg[i] <= RESET_MAP[8*i +: 8];
         end
      end else begin
         iows_d <= iows;
         if (iow_edge) begin
            cfg[cfg_idx] <= d_i;
         end else if (hs_edge) begin
            cfg[HOT_IDX][PG_HI:PG_LO] <= hs_page;
         end
      end
   end

   always_comb begin
      src_ce_n_o = '1;
      if (!reset_i && !mreq_n_i && rfsh_n_i) begin
         src_ce_n_o[cur_src] = 1'b0;
      end
   end

   always_comb begin
      cfg_rd_en_o   = 1'b0;
      cfg_rd_data_o = 8'h00;
      if (!reset_i && iors) begin
         cfg_rd_en_o   = 1'b1;
         cfg_rd_data_o = cfg[cfg_idx];
      end
   end

endmodule
